// File: rtl/srt_div_pkg.sv
// Shared types and FP32 constants for the SRT divider post-processing stage.
package srt_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CORR,
    S_NORM,
    S_RND,
    S_OUT
  } state_e;

  typedef enum logic [1:0] {
    SP_NORMAL = 2'b00,
    SP_ZERO   = 2'b01,
    SP_INF    = 2'b10,
    SP_NAN    = 2'b11
  } special_e;

  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam int          QUO_W        = 26;
  localparam int          MANT_W       = 24;

endpackage

// File: rtl/srt_div_fp32_post_if.sv
// Upstream/downstream handshake bundle of srt_div_fp32_post.
// exc_flags exists only when FP32_DIV_EXC_FLAGS_EN is defined.
interface srt_div_fp32_post_if;
  import srt_div_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [QUO_W-1:0]         quo;
  logic                     rem_nz;
  logic                     rem_neg;
  logic signed [9:0]        exp_in;
  logic                     sign_in;
  logic [1:0]               special;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              result;
`ifdef FP32_DIV_EXC_FLAGS_EN
  logic [2:0]               exc_flags;

  modport master (
    output in_valid, quo, rem_nz, rem_neg, exp_in, sign_in, special, out_ready,
    input  in_ready, out_valid, result, exc_flags
  );
  modport slave (
    input  in_valid, quo, rem_nz, rem_neg, exp_in, sign_in, special, out_ready,
    output in_ready, out_valid, result, exc_flags
  );
`else
  modport master (
    output in_valid, quo, rem_nz, rem_neg, exp_in, sign_in, special, out_ready,
    input  in_ready, out_valid, result
  );
  modport slave (
    input  in_valid, quo, rem_nz, rem_neg, exp_in, sign_in, special, out_ready,
    output in_ready, out_valid, result
  );
`endif
endinterface

// File: rtl/fp32_round_rne.sv
// Combinational round-to-nearest-even of a 24-bit mantissa with guard/sticky.
// The inexact output exists only when FP32_DIV_EXC_FLAGS_EN is defined.
module fp32_round_rne
  import srt_div_pkg::*;
(
  input  logic [MANT_W-1:0] mant,
  input  logic              guard,
  input  logic              sticky,
  output logic [MANT_W-1:0] mant_rnd,
  output logic              carry
`ifdef FP32_DIV_EXC_FLAGS_EN
  ,
  output logic              inexact
`endif
);

  logic            round_up;
  logic [MANT_W:0] sum;

  assign round_up = guard & (sticky | mant[0]);
  assign sum      = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign carry    = sum[MANT_W];
  // Carry-out only happens from all-ones, so the renormalized mantissa is 1.0.
  assign mant_rnd = carry ? {1'b1, {(MANT_W-1){1'b0}}} : sum[MANT_W-1:0];

`ifdef FP32_DIV_EXC_FLAGS_EN
  assign inexact  = guard | sticky;
`endif

endmodule

// File: rtl/srt_div_fp32_post.sv
// FP32 SRT divider post-processing: remainder correction, normalize, RNE round, pack.
// Optional exception flags under FP32_DIV_EXC_FLAGS_EN.
module srt_div_fp32_post
  import srt_div_pkg::*;
(
  input logic                clk,
  input logic                rst,
  srt_div_fp32_post_if.slave bus
);

  state_e state, state_nxt;

  logic [QUO_W-1:0]  quo_p0;
  logic              rem_nz_p0, rem_neg_p0, sign_p0;
  logic signed [9:0] exp_p0;
  special_e          special_p0;

  logic [QUO_W-1:0]  q_p1;
  logic              sticky_p1;

  logic [MANT_W-1:0] mant_p2;
  logic              guard_p2, sticky_p2;
  logic signed [9:0] exp_p2;

  logic [MANT_W-1:0] mant_rnd;
  logic              carry_rnd;
  logic signed [9:0] exp_rnd;
  logic [31:0]       result_q;

  function automatic logic [31:0] pack_fp32(input logic sign, input special_e sp,
                                            input logic signed [9:0] e,
                                            input logic [22:0] frac);
    logic [31:0] r;
    case (sp)
      SP_ZERO: r = {sign, 31'h0};
      SP_INF:  r = {sign, 8'hFF, 23'h0};
      SP_NAN:  r = FP32_QNAN;
      default: begin
        if (e >= FP32_EXP_MAX)  r = {sign, 8'hFF, 23'h0};
        else if (e <= 0)        r = {sign, 31'h0};
        else                    r = {sign, e[7:0], frac};
      end
    endcase
    return r;
  endfunction

`ifdef FP32_DIV_EXC_FLAGS_EN
  logic       inexact_rnd;
  logic [2:0] flags_q;

  function automatic logic [2:0] sat_flags(input special_e sp, input logic signed [9:0] e,
                                           input logic inexact);
    logic [2:0] f;
    if (sp != SP_NORMAL)        f = 3'b000;
    else if (e >= FP32_EXP_MAX) f = 3'b101;
    else if (e <= 0)            f = 3'b011;
    else                        f = {2'b00, inexact};
    return f;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.in_valid) state_nxt = S_CORR;
      S_CORR:  state_nxt = S_NORM;
      S_NORM:  state_nxt = S_RND;
      S_RND:   state_nxt = S_OUT;
      S_OUT:   if (bus.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    case (state)
      // p0: capture upstream operands
      S_IDLE: if (bus.in_valid) begin
        quo_p0     <= bus.quo;
        rem_nz_p0  <= bus.rem_nz;
        rem_neg_p0 <= bus.rem_neg;
        exp_p0     <= bus.exp_in;
        sign_p0    <= bus.sign_in;
        special_p0 <= special_e'(bus.special);
      end
      // p1: negative-remainder correction
      S_CORR: begin
        q_p1      <= rem_neg_p0 ? quo_p0 - 26'd1 : quo_p0;
        sticky_p1 <= rem_nz_p0;
      end
      // p2: one-bit normalization
      S_NORM: begin
        if (q_p1[QUO_W-1]) begin
          mant_p2   <= q_p1[QUO_W-1:2];
          guard_p2  <= q_p1[1];
          sticky_p2 <= q_p1[0] | sticky_p1;
          exp_p2    <= exp_p0;
        end else begin
          mant_p2   <= q_p1[QUO_W-2:1];
          guard_p2  <= q_p1[0];
          sticky_p2 <= sticky_p1;
          exp_p2    <= exp_p0 - 10'sd1;
        end
      end
      default: ;
    endcase
  end

  fp32_round_rne u_round (
    .mant     (mant_p2),
    .guard    (guard_p2),
    .sticky   (sticky_p2),
    .mant_rnd (mant_rnd),
    .carry    (carry_rnd)
`ifdef FP32_DIV_EXC_FLAGS_EN
    ,
    .inexact  (inexact_rnd)
`endif
  );

  assign exp_rnd = exp_p2 + $signed({9'b0, carry_rnd});

  // Output register: loaded once in S_RND, held through S_OUT backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 32'h0;
`ifdef FP32_DIV_EXC_FLAGS_EN
      flags_q  <= 3'b000;
`endif
    end else if (state == S_RND) begin
      result_q <= pack_fp32(sign_p0, special_p0, exp_rnd, mant_rnd[22:0]);
`ifdef FP32_DIV_EXC_FLAGS_EN
      flags_q  <= sat_flags(special_p0, exp_rnd, inexact_rnd);
`endif
    end
  end

  assign bus.result = result_q;
`ifdef FP32_DIV_EXC_FLAGS_EN
  assign bus.exc_flags = flags_q;
`endif

endmodule
